// File: rtl/edge_implication_monitor.sv
// Multi-channel checker for "trig[i] |-> ##DELAY edge(val[i])" with pass/fail pulses,
// a saturating fail counter and first-failure capture. Optional: EDGE_MON_STOP_EN.
module edge_implication_monitor #(
    parameter int WIDTH = 8,
    parameter int DELAY = 1,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [WIDTH-1:0]       val,
    input  logic [WIDTH-1:0]       trig,
    input  logic [1:0]             mode,
    output logic [WIDTH-1:0]       pass,
    output logic [WIDTH-1:0]       fail,
    output logic [CNT_W-1:0]       fail_count,
    output logic                   first_fail_valid,
    output logic [$clog2(WIDTH):0] first_fail_chan,
    output logic [1:0]             first_fail_mode
);

    typedef enum logic [1:0] {
        MODE_FELL    = 2'b00,
        MODE_ROSE    = 2'b01,
        MODE_STABLE  = 2'b10,
        MODE_CHANGED = 2'b11
    } edge_mode_e;

    localparam int CH_W  = $clog2(WIDTH) + 1;
    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int SUM_W = CNT_W + POP_W;
    localparam logic [SUM_W-1:0] CNT_MAX = {{POP_W{1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] prevVal;
    logic [WIDTH-1:0] capTrig;
    logic [WIDTH-1:0] evalTrig;
    logic [1:0]       evalMode;
    logic [WIDTH-1:0] edgeOk;
    logic [WIDTH-1:0] passNext;
    logic [WIDTH-1:0] failNext;
    logic [POP_W-1:0] failPop;
    logic [SUM_W-1:0] sumWide;
    logic [CNT_W-1:0] satCount;
    logic [CH_W-1:0]  firstIdx;

    assign capTrig = en ? trig : '0;

    // Each stage carries the antecedent bits and the mode captured alongside them,
    // so a mode change never reaches checks that are already in flight.
    generate
        if (DELAY == 0) begin : g_overlap
            assign evalTrig = capTrig;
            assign evalMode = mode;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipeTrig [DELAY];
            logic [1:0]       pipeMode [DELAY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DELAY; k++) begin
                        pipeTrig[k] <= '0;
                        pipeMode[k] <= 2'b00;
                    end
                end else begin
                    pipeTrig[0] <= capTrig;
                    pipeMode[0] <= mode;
                    for (int k = 1; k < DELAY; k++) begin
                        pipeTrig[k] <= pipeTrig[k-1];
                        pipeMode[k] <= pipeMode[k-1];
                    end
                end
            end

            assign evalTrig = pipeTrig[DELAY-1];
            assign evalMode = pipeMode[DELAY-1];
        end
    endgenerate

    always_comb begin
        edgeOk = '0;
        case (edge_mode_e'(evalMode))
            MODE_FELL:    edgeOk = prevVal & ~val;
            MODE_ROSE:    edgeOk = ~prevVal & val;
            MODE_STABLE:  edgeOk = ~(prevVal ^ val);
            MODE_CHANGED: edgeOk = prevVal ^ val;
            default:      edgeOk = '0;
        endcase
    end

    assign passNext = evalTrig & edgeOk;
    assign failNext = evalTrig & ~edgeOk;

    // Popcount, saturating sum and lowest failing channel for this edge.
    always_comb begin
        failPop  = '0;
        firstIdx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            failPop = failPop + POP_W'(failNext[i]);
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (failNext[i]) begin
                firstIdx = CH_W'(i);
            end
        end
        sumWide  = SUM_W'(fail_count) + SUM_W'(failPop);
        satCount = (sumWide > CNT_MAX) ? {CNT_W{1'b1}} : sumWide[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevVal          <= '0;
            pass             <= '0;
            fail             <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_chan  <= '0;
            first_fail_mode  <= 2'b00;
        end else begin
            prevVal    <= val;
            pass       <= passNext;
            fail       <= failNext;
            fail_count <= satCount;
            if (!first_fail_valid && (failNext != '0)) begin
                first_fail_valid <= 1'b1;
                first_fail_chan  <= firstIdx;
                first_fail_mode  <= evalMode;
            end
        end
    end

`ifdef EDGE_MON_STOP_EN
    always @(posedge clk) begin
        if (!rst && (failNext != '0)) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (failNext[i]) begin
                    $display("edge_mon fail ch=%0d mode=%0d t=%0t", i, evalMode, $time);
                end
            end
            $stop;
        end
    end
`endif

endmodule

// File: tb/tb_edge_implication_monitor.sv
// Bench for edge_implication_monitor: two instances (DELAY=3 with a 4-bit counter,
// DELAY=0 with a 16-bit counter) checked against a history-based reference model.
module tb_edge_implication_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] val;
    logic [3:0] trig;
    logic [1:0] mode;

    logic [3:0]  passA, failA, cntA;
    logic        ffvA;
    logic [2:0]  ffcA;
    logic [1:0]  ffmA;
    logic [3:0]  passB, failB;
    logic [15:0] cntB;
    logic        ffvB;
    logic [2:0]  ffcB;
    logic [1:0]  ffmB;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: full sampled history since the last reset.
    logic [3:0] valH[$];
    logic [3:0] trgH[$];
    logic [1:0] modeH[$];
    logic [3:0] expPassA, expFailA, expPassB, expFailB;
    int         expCntA, expCntB;
    logic       expFfvA, expFfvB;
    logic [2:0] expFfcA, expFfcB;
    logic [1:0] expFfmA, expFfmB;

    edge_implication_monitor #(.WIDTH(4), .DELAY(3), .CNT_W(4)) dutA (
        .clk(clk), .rst(rst), .en(en), .val(val), .trig(trig), .mode(mode),
        .pass(passA), .fail(failA), .fail_count(cntA),
        .first_fail_valid(ffvA), .first_fail_chan(ffcA), .first_fail_mode(ffmA)
    );

    edge_implication_monitor #(.WIDTH(4), .DELAY(0), .CNT_W(16)) dutB (
        .clk(clk), .rst(rst), .en(en), .val(val), .trig(trig), .mode(mode),
        .pass(passB), .fail(failB), .fail_count(cntB),
        .first_fail_valid(ffvB), .first_fail_chan(ffcB), .first_fail_mode(ffmB)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] edgeHolds(input logic [1:0] m, input logic [3:0] p, input logic [3:0] c);
        case (m)
            2'd0:    return p & ~c;
            2'd1:    return ~p & c;
            2'd2:    return ~(p ^ c);
            default: return p ^ c;
        endcase
    endfunction

    task automatic modelEval(input int d, output logic [3:0] ep, output logic [3:0] ef, output logic [1:0] em);
        int n;
        logic [3:0] prev;
        logic [3:0] ok;
        n = valH.size() - 1;
        prev = (n > 0) ? valH[n-1] : 4'h0;
        ep = 4'h0;
        ef = 4'h0;
        em = 2'd0;
        if (n >= d) begin
            em = modeH[n-d];
            ok = edgeHolds(em, prev, valH[n]);
            ep = trgH[n-d] & ok;
            ef = trgH[n-d] & ~ok;
        end
    endtask

    task automatic modelUpdate(input logic [3:0] ef, input logic [1:0] em, input int cmax,
                               inout int cnt, inout logic ffv, inout logic [2:0] ffc, inout logic [1:0] ffm);
        cnt = cnt + $countones(ef);
        if (cnt > cmax) cnt = cmax;
        if (!ffv && ef != 4'h0) begin
            ffv = 1'b1;
            ffm = em;
            for (int i = 3; i >= 0; i--) if (ef[i]) ffc = 3'(i);
        end
    endtask

    task automatic modelClear();
        valH.delete();
        trgH.delete();
        modeH.delete();
        expPassA = 0; expFailA = 0; expPassB = 0; expFailB = 0;
        expCntA = 0;  expCntB = 0;
        expFfvA = 0;  expFfvB = 0;
        expFfcA = 0;  expFfcB = 0;
        expFfmA = 0;  expFfmB = 0;
    endtask

    task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkOutput();
        checkOne("A.pass", 32'(passA), 32'(expPassA));
        checkOne("A.fail", 32'(failA), 32'(expFailA));
        checkOne("A.count", 32'(cntA), 32'(expCntA));
        checkOne("A.ffValid", 32'(ffvA), 32'(expFfvA));
        checkOne("A.ffChan", 32'(ffcA), 32'(expFfcA));
        checkOne("A.ffMode", 32'(ffmA), 32'(expFfmA));
        checkOne("B.pass", 32'(passB), 32'(expPassB));
        checkOne("B.fail", 32'(failB), 32'(expFailB));
        checkOne("B.count", 32'(cntB), 32'(expCntB));
        checkOne("B.ffValid", 32'(ffvB), 32'(expFfvB));
        checkOne("B.ffChan", 32'(ffcB), 32'(expFfcB));
        checkOne("B.ffMode", 32'(ffmB), 32'(expFfmB));
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, then compare.
    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] t, input logic e, input logic [1:0] m);
        logic [1:0] emA, emB;
        val  = v;
        trig = t;
        en   = e;
        mode = m;
        @(posedge clk);
        valH.push_back(v);
        trgH.push_back(e ? t : 4'h0);
        modeH.push_back(m);
        modelEval(3, expPassA, expFailA, emA);
        modelEval(0, expPassB, expFailB, emB);
        modelUpdate(expFailA, emA, 15, expCntA, expFfvA, expFfcA, expFfmA);
        modelUpdate(expFailB, emB, 65535, expCntB, expFfvB, expFfcB, expFfmB);
        #1;
        checkOutput();
    endtask

    // Assert reset mid-cycle, check that outputs clear at once, release on a falling edge.
    task automatic doReset();
        #2 rst = 1'b1;
        #1;
        modelClear();
        checkOutput();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; val = 4'h0; trig = 4'h0; mode = 2'd0;
        modelClear();
        @(negedge clk);
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        // Overlapping CHANGED: 0 -> 5 with all channels triggered.
        applyStimulus(4'h0, 4'h0, 1'b1, 2'd3);
        applyStimulus(4'h5, 4'hF, 1'b1, 2'd3);
        checkOne("dir3.pass", 32'(passB), 32'h5);
        checkOne("dir3.fail", 32'(failB), 32'hA);
        checkOne("dir3.count", 32'(cntB), 32'd2);
        checkOne("dir3.ffChan", 32'(ffcB), 32'd1);

        // ROSE captured, mode switched to STABLE afterwards, rise lands at E+3.
        doReset();
        applyStimulus(4'h0, 4'h1, 1'b1, 2'd1);
        applyStimulus(4'h0, 4'h0, 1'b1, 2'd2);
        applyStimulus(4'h0, 4'h0, 1'b1, 2'd2);
        applyStimulus(4'h1, 4'h0, 1'b1, 2'd2);
        checkOne("dir4.pass", 32'(passA), 32'h1);
        checkOne("dir4.fail", 32'(failA), 32'h0);

        // Fill the pipe, then reset mid-cycle; discarded checks must produce nothing.
        applyStimulus(4'hF, 4'hF, 1'b1, 2'd0);
        applyStimulus(4'h0, 4'hF, 1'b1, 2'd3);
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(4'h0, 4'h0, 1'b0, 2'd0);
        checkOne("dir5.countA", 32'(cntA), 32'd0);

        // Random traffic; en occasionally low, mid-run reset.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) doReset();
            applyStimulus(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
